// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU memory stage (port 0) and loader/debug
// port (port 1) share one combinational-read datamem. Round-robin between
// contenders, with an optional lock that keeps ownership for a bounded run.
module dmem_arbiter #(
  parameter int EXT_WIDTH = 32,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [EXT_WIDTH-1:0] addr0,
  input  logic [EXT_WIDTH-1:0] addr1,
  input  logic [EXT_WIDTH-1:0] wdata0,
  input  logic [EXT_WIDTH-1:0] wdata1,
  input  logic                 lock0,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [EXT_WIDTH-1:0] rdata0,
  output logic [EXT_WIDTH-1:0] rdata1,
  output logic [EXT_WIDTH-1:0] mem_A,
  output logic [EXT_WIDTH-1:0] mem_WD,
  output logic                 mem_WE,
  input  logic [EXT_WIDTH-1:0] mem_RD
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             rr;          // index of the requester that won last
  logic [CNT_W-1:0] lock_cnt;    // grants so far in the current locked run
  logic [CNT_W-1:0] cnt_inc;
  logic             gnt0_raw;
  logic             gnt1_raw;
  logic             rvalid0_p1;
  logic             rvalid1_p1;

  assign cnt_inc = lock_cnt + CNT_W'(1);

  // Grant decision: owner-only while locked, otherwise the requester rr does not name.
  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    unique case (state)
      OWN0:    gnt0_raw = req0;
      OWN1:    gnt1_raw = req1;
      default: begin
        if (req0 && req1) begin
          gnt0_raw = rr;
          gnt1_raw = ~rr;
        end else begin
          gnt0_raw = req0;
          gnt1_raw = req1;
        end
      end
    endcase
  end

  // Reset blanks the grants in the same cycle so nothing reaches the memory.
  assign gnt0 = gnt0_raw & ~rst;
  assign gnt1 = gnt1_raw & ~rst;

  // Memory-side mux of the granted requester; all zero when idle.
  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    if (gnt0) begin
      mem_A  = addr0;
      mem_WD = wdata0;
      mem_WE = we0;
    end else if (gnt1) begin
      mem_A  = addr1;
      mem_WD = wdata1;
      mem_WE = we1;
    end
  end

  // Ownership FSM with round-robin pointer and bounded lock run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= 1'b1;
      lock_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (gnt0) begin
            rr <= 1'b0;
            if (lock0 && (LOCK_MAX > 1)) begin
              state    <= OWN0;
              lock_cnt <= CNT_W'(1);
            end
          end else if (gnt1) begin
            rr <= 1'b1;
            if (lock1 && (LOCK_MAX > 1)) begin
              state    <= OWN1;
              lock_cnt <= CNT_W'(1);
            end
          end
        end
        OWN0: begin
          // Leaving with rr=0 at the run limit lets a waiting port 1 win next.
          rr <= 1'b0;
          if (gnt0 && lock0 && (cnt_inc != CNT_W'(LOCK_MAX))) begin
            lock_cnt <= cnt_inc;
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        OWN1: begin
          rr <= 1'b1;
          if (gnt1 && lock1 && (cnt_inc != CNT_W'(LOCK_MAX))) begin
            lock_cnt <= cnt_inc;
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // Read return stage: capture mem_RD on a granted read, pulse valid next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      rvalid0_p1 <= gnt0 & ~we0;
      rvalid1_p1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_RD;
      if (gnt1 && !we1) rdata1 <= mem_RD;
    end
  end

  // A read granted just before reset must not report valid during the reset cycle.
  assign rvalid0 = rvalid0_p1 & ~rst;
  assign rvalid1 = rvalid1_p1 & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration/memory model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam int W  = 32;
  localparam int LM = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1, lock0, lock1;
  logic [W-1:0] addr0, addr1, wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1, mem_WE;
  logic [W-1:0] rdata0, rdata1, mem_A, mem_WD, mem_RD;

  logic [W-1:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.EXT_WIDTH(W), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Datamem: combinational read, write on the rising edge (old value read).
  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: who holds the lock (-1 none), length of the run, last winner.
  int           m_lockto = -1;
  int           m_run    = 0;
  int           m_last   = 1;
  logic         m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [W-1:0] m_rd0 = '0, m_rd1 = '0;

  // Compare process: inputs are stable between posedge+1 and the next posedge.
  always @(negedge clk) begin : cmp
    int           g;
    logic         lk;
    logic         ewe;
    logic [W-1:0] ea, ewd;
    if (rst)                 g = -1;
    else if (m_lockto == 0)  g = req0 ? 0 : -1;
    else if (m_lockto == 1)  g = req1 ? 1 : -1;
    else if (req0 && req1)   g = 1 - m_last;
    else if (req0)           g = 0;
    else if (req1)           g = 1;
    else                     g = -1;
    ea  = (g == 0) ? addr0  : (g == 1) ? addr1  : '0;
    ewd = (g == 0) ? wdata0 : (g == 1) ? wdata1 : '0;
    ewe = (g == 0) ? we0    : (g == 1) ? we1    : 1'b0;
    chk("m_gnt0",    W'(gnt0),    W'(g == 0));
    chk("m_gnt1",    W'(gnt1),    W'(g == 1));
    chk("m_mem_WE",  W'(mem_WE),  W'(ewe));
    chk("m_mem_A",   mem_A,       ea);
    chk("m_mem_WD",  mem_WD,      ewd);
    chk("m_rvalid0", W'(rvalid0), W'(m_rv0 & ~rst));
    chk("m_rvalid1", W'(rvalid1), W'(m_rv1 & ~rst));
    chk("m_rdata0",  rdata0,      m_rd0);
    chk("m_rdata1",  rdata1,      m_rd1);
    if (rst) begin
      m_lockto = -1; m_run = 0; m_last = 1;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rv0 = (g == 0) && !we0;
      m_rv1 = (g == 1) && !we1;
      if (m_rv0) m_rd0 = mem[addr0[9:2]];
      if (m_rv1) m_rd1 = mem[addr1[9:2]];
      if (g >= 0) begin
        m_run  = (m_lockto == g) ? m_run + 1 : 1;
        m_last = g;
        lk     = (g == 0) ? lock0 : lock1;
        if (lk && m_run < LM) m_lockto = g;
        else begin m_lockto = -1; m_run = 0; end
      end else begin
        m_lockto = -1; m_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int seq [18];
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
    mem[4] = 32'hDEAD_BEEF;   // byte address 0x10
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h4; wdata0 = '0; wdata1 = '0;

    // Reset with both requesting
    #2;
    chk("rst_gnt0", W'(gnt0), 0);
    chk("rst_gnt1", W'(gnt1), 0);
    chk("rst_we",   W'(mem_WE), 0);
    tick(); tick();
    rst = 1'b0;

    // Contention without lock: 0,1,0,1 with rvalid trailing each read
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("contend_gnt0", W'(gnt0), W'(i % 2 == 0));
      chk("contend_gnt1", W'(gnt1), W'(i % 2 == 1));
      if (i > 0) chk("contend_rvalid", W'((i % 2 == 1) ? rvalid0 : rvalid1), 1);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Read of preloaded word by port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
    #2 chk("read_gnt1", W'(gnt1), 1);
    tick();
    req1 = 1'b0;
    #2;
    chk("read_rvalid1", W'(rvalid1), 1);
    chk("read_rdata1",  rdata1, 32'hDEAD_BEEF);
    chk("read_rvalid0", W'(rvalid0), 0);
    tick();

    // Write by port 0, then read it back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    #2;
    chk("wr_mem_WE", W'(mem_WE), 1);
    chk("wr_mem_A",  mem_A, 32'h20);
    tick();
    we0 = 1'b0; wdata0 = '0;
    #2;
    chk("wr_no_rvalid", W'(rvalid0), 0);
    chk("rb_gnt0",      W'(gnt0), 1);
    tick();
    req0 = 1'b0;
    #2;
    chk("rb_rvalid0", W'(rvalid0), 1);
    chk("rb_rdata0",  rdata0, 32'h1234_5678);
    tick();

    // Back-to-back reads by port 1
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; addr1 = 32'(i * 4);
      #2;
      chk("b2b_gnt1", W'(gnt1), 1);
      if (i > 0) chk("b2b_rvalid1", W'(rvalid1), 1);
      tick();
    end
    req1 = 1'b0;
    tick();

    // Lock run limit: port 0 locked, port 1 waiting
    req0 = 1'b1; lock0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h20;
    for (int i = 0; i < 18; i++) begin
      #2 seq[i] = gnt0 ? 0 : (gnt1 ? 1 : 2);
      tick();
    end
    req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
    n = 0;
    while (n < 18 && seq[n] == 0) n++;
    chk("lock_run",    W'(n), 16);
    chk("lock_yield",  W'(seq[16]), 1);
    chk("lock_resume", W'(seq[17]), 0);
    tick();

    // Reset during an OWN1 read
    req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h10;
    tick();
    req0 = 1'b1; addr0 = 32'h0;
    #2;
    chk("own1_gnt1",    W'(gnt1), 1);
    chk("own1_holdoff", W'(gnt0), 0);
    tick();
    rst = 1'b1;
    #2;
    chk("rstlk_rvalid1", W'(rvalid1), 0);
    chk("rstlk_gnt",     W'(gnt0 | gnt1), 0);
    tick();
    rst = 1'b0; lock1 = 1'b0;
    #2;
    chk("post_rst_rvalid1", W'(rvalid1), 0);
    chk("post_rst_gnt0",    W'(gnt0), 1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
